sweep_ctrl: RTL and testbench

SWEEP_CTRL -- requirements
Module: sweep_ctrl

---
 rtl/sweep_ctrl_pkg.sv | 17 +
 rtl/sweep_ctrl_dwell_timer.sv | 29 ++
 rtl/sweep_ctrl.sv | 170 +++++++++++++++++
 tb/tb_sweep_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_ctrl_pkg.sv
// Shared definitions for the sweep controller: state encoding and default widths.
package sweep_ctrl_pkg;

    localparam int CW_DEF = 4;
    localparam int DW_DEF = 4;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SEEK     = 3'd1,
        S_UP       = 3'd2,
        S_DWELL_HI = 3'd3,
        S_DOWN     = 3'd4,
        S_DWELL_LO = 3'd5,
        S_DONE     = 3'd6
    } state_t;

endpackage

// File: rtl/sweep_ctrl_dwell_timer.sv
// Endpoint hold timer: loads a cycle count and counts it down to zero.
module dwell_timer
    import sweep_ctrl_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] load_val,
    output logic          expired
);

    logic [DW-1:0] remain;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            remain <= '0;
        end else if (load) begin
            remain <= load_val;
        end else if (remain != '0) begin
            remain <= remain - DW'(1);
        end
    end

    // Loaded with dwell on the entry edge, so the hold lasts dwell+1 cycles.
    assign expired = (remain == '0);

endmodule

// File: rtl/sweep_ctrl.sv
// Drives an external up/down counter back and forth between lo and hi,
// holding at each endpoint, for a fixed or unbounded number of sweeps.
module sweep_ctrl
    import sweep_ctrl_pkg::*;
#(
    parameter int CW = CW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] lo,
    input  logic [CW-1:0] hi,
    input  logic [DW-1:0] dwell,
    input  logic [DW-1:0] sweeps,
    input  logic [CW-1:0] cnt_in,
    output logic          cnt_en,
    output logic          mode,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] sweep_cnt
);

    state_t        state;
    logic [CW-1:0] lo_q;
    logic [CW-1:0] hi_q;
    logic [CW-1:0] cnt_prev;
    logic [DW-1:0] dwell_q;
    logic [DW-1:0] sweeps_q;
    logic [DW-1:0] sweep_nxt;
    logic [1:0]    stall_cnt;
    logic          moving;
    logic          at_target;
    logic          stalled;
    logic          dwell_load;
    logic          dwell_exp;

    always_comb begin
        moving    = 1'b0;
        at_target = 1'b0;
        case (state)
            S_SEEK, S_DOWN: begin
                moving    = 1'b1;
                at_target = (cnt_in == lo_q);
            end
            S_UP: begin
                moving    = 1'b1;
                at_target = (cnt_in == hi_q);
            end
            default: begin
                moving    = 1'b0;
                at_target = 1'b0;
            end
        endcase
    end

    // Gated by the live target compare so the counter never steps past an endpoint.
    assign cnt_en     = rst_n && !abort && moving && !at_target;
    assign stalled    = cnt_en && (cnt_in == cnt_prev);
    assign dwell_load = !abort && at_target && ((state == S_UP) || (state == S_DOWN));
    assign sweep_nxt  = sweep_cnt + DW'(1);

    dwell_timer #(
        .DW(DW)
    ) u_dwell (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (dwell_load),
        .load_val(dwell_q),
        .expired (dwell_exp)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            mode      <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            sweep_cnt <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            dwell_q   <= '0;
            sweeps_q  <= '0;
            stall_cnt <= '0;
            cnt_prev  <= '0;
        end else begin
            done      <= 1'b0;
            err       <= 1'b0;
            cnt_prev  <= cnt_in;
            stall_cnt <= stalled ? stall_cnt + 2'd1 : 2'd0;

            if ((state != S_IDLE) && abort) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else if (stalled && (stall_cnt == 2'd2)) begin
                // Third consecutive request the counter ignored.
                state     <= S_IDLE;
                busy      <= 1'b0;
                err       <= 1'b1;
                stall_cnt <= 2'd0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            if (lo < hi) begin
                                lo_q      <= lo;
                                hi_q      <= hi;
                                dwell_q   <= dwell;
                                sweeps_q  <= sweeps;
                                sweep_cnt <= '0;
                                mode      <= (cnt_in < lo);
                                busy      <= 1'b1;
                                state     <= S_SEEK;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    S_SEEK: begin
                        if (at_target) begin
                            mode  <= 1'b1;
                            state <= S_UP;
                        end
                    end
                    S_UP: begin
                        if (at_target) begin
                            state <= S_DWELL_HI;
                        end
                    end
                    S_DWELL_HI: begin
                        if (dwell_exp) begin
                            mode  <= 1'b0;
                            state <= S_DOWN;
                        end
                    end
                    S_DOWN: begin
                        if (at_target) begin
                            state <= S_DWELL_LO;
                        end
                    end
                    S_DWELL_LO: begin
                        if (dwell_exp) begin
                            sweep_cnt <= sweep_nxt;
                            // sweeps_q == 0 means run until aborted.
                            if ((sweeps_q != '0) && (sweep_nxt == sweeps_q)) begin
                                done  <= 1'b1;
                                state <= S_DONE;
                            end else begin
                                mode  <= 1'b1;
                                state <= S_UP;
                            end
                        end
                    end
                    S_DONE: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sweep_ctrl.sv
// Bench for sweep_ctrl paired with a behavioural 4-bit up/down counter.
module tb_sweep_ctrl;
    import sweep_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] lo = '0, hi = '0, dwell = '0, sweeps = '0;
    logic [3:0] cnt = '0;
    logic       cnt_en, mode, busy, done, err;
    logic [3:0] sweep_cnt;
    logic       ld = 1'b1, freeze = 1'b0;
    logic [3:0] ld_val = '0;
    int         checks = 0;
    int         errors = 0;

    typedef struct packed {
        logic       en;
        logic       md;
        logic       bz;
        logic       dn;
        logic       er;
        logic [3:0] sc;
    } exp_t;

    typedef struct {
        logic       st;
        logic       ab;
        logic [3:0] l;
        logic [3:0] h;
        logic       e_err;
        logic       e_busy;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[6];

    always #5 clk = ~clk;

    sweep_ctrl #(.CW(4), .DW(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .lo       (lo),
        .hi       (hi),
        .dwell    (dwell),
        .sweeps   (sweeps),
        .cnt_in   (cnt),
        .cnt_en   (cnt_en),
        .mode     (mode),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .sweep_cnt(sweep_cnt)
    );

    always @(posedge clk) begin
        if (ld) cnt <= ld_val;
        else if (cnt_en && !freeze) cnt <= mode ? cnt + 4'd1 : cnt - 4'd1;
    end

    task automatic check(input string nm, input logic [8:0] got, input logic [8:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got en/md/bz/dn/er=%b sc=%0d, expected en/md/bz/dn/er=%b sc=%0d",
                     nm, got[8:4], got[3:0], want[8:4], want[3:0]);
        end
    endtask

    function automatic logic [8:0] outs();
        return {cnt_en, mode, busy, done, err, sweep_cnt};
    endfunction

    function automatic void push(int n, logic en, logic md, logic bz, logic dn, int s);
        exp_t e;
        e = '{en: en, md: md, bz: bz, dn: dn, er: 1'b0, sc: 4'(s)};
        for (int k = 0; k < n; k++) exp_q.push_back(e);
    endfunction

    // Expected per-cycle outputs from the sweep rules: every counter step costs
    // a cycle, reaching a target costs one more, each endpoint holds dwell+1.
    function automatic void build(int c0, int l, int h, int dw, int sw, int ncont);
        int  s = 0;
        int  ndone = 0;
        bit  fin = 0;
        logic dir = (c0 < l);
        exp_q.delete();
        push((c0 > l) ? c0 - l : l - c0, 1, dir, 1, 0, 0);
        push(1, 0, dir, 1, 0, 0);
        while (!fin) begin
            push(h - l, 1, 1, 1, 0, s);
            push(1, 0, 1, 1, 0, s);
            push(dw + 1, 0, 1, 1, 0, s);
            push(h - l, 1, 0, 1, 0, s);
            push(1, 0, 0, 1, 0, s);
            push(dw + 1, 0, 0, 1, 0, s);
            ndone++;
            s = ndone % 16;
            if (sw != 0 && ndone == sw) begin
                push(1, 0, 0, 1, 1, s);
                push(1, 0, 0, 0, 0, s);
                fin = 1;
            end else if (sw == 0 && ndone == ncont) begin
                push(h - l, 1, 1, 1, 0, s);
                push(1, 0, 1, 1, 0, s);
                push(dw + 1, 0, 1, 1, 0, s);
                push(1, 0, 0, 1, 0, s);   // first DOWN step, suppressed by abort
                push(1, 0, 0, 0, 0, s);
                fin = 1;
            end
        end
    endfunction

    task automatic kick(input int l, input int h, input int d, input int s);
        @(negedge clk);
        lo = 4'(l); hi = 4'(h); dwell = 4'(d); sweeps = 4'(s);
        abort = 1'b0; start = 1'b1;
    endtask

    task automatic run_q(input string nm, input bit noise, input bit abort_last, input int limit);
        int n;
        n = (limit < 0) ? exp_q.size() : limit;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = 1'b0;
            abort = abort_last && (i == exp_q.size() - 2);
            if (noise && i < exp_q.size() - 1) begin
                start  = 1'($urandom_range(0, 1));
                lo     = 4'($urandom);
                hi     = 4'($urandom);
                dwell  = 4'($urandom);
                sweeps = 4'($urandom);
            end
            #1;
            check($sformatf("%s[%0d]", nm, i), outs(), exp_q[i]);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        int l, h, d, s;

        tbl[0] = '{st: 1, ab: 0, l: 5,  h: 5,  e_err: 1, e_busy: 0};
        tbl[1] = '{st: 1, ab: 0, l: 9,  h: 3,  e_err: 1, e_busy: 0};
        tbl[2] = '{st: 1, ab: 0, l: 15, h: 0,  e_err: 1, e_busy: 0};
        tbl[3] = '{st: 1, ab: 0, l: 3,  h: 4,  e_err: 0, e_busy: 1};
        tbl[4] = '{st: 1, ab: 1, l: 1,  h: 14, e_err: 0, e_busy: 1};
        tbl[5] = '{st: 0, ab: 1, l: 2,  h: 9,  e_err: 0, e_busy: 0};

        // Reset state, counter parked at 0
        repeat (3) @(negedge clk);
        #1 check("reset", outs(), 9'b0_1_0_0_0_0000);
        rst_n = 1'b1;
        ld = 1'b0;

        // lo=2 hi=5 dwell=1 one sweep
        kick(2, 5, 1, 1);
        build(cnt, 2, 5, 1, 1, 0);
        run_q("basic", 0, 0, -1);
        check("basic_cnt_end", {5'b0, cnt}, {5'b0, 4'd2});

        // Start validation and start/abort priority
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = tbl[i].st; abort = tbl[i].ab; lo = tbl[i].l; hi = tbl[i].h;
            @(negedge clk);
            start = 1'b0;
            abort = tbl[i].e_busy;
            #1;
            check($sformatf("tbl%0d_a", i), {cnt_en, busy, err, done, 5'b0},
                  {1'b0, tbl[i].e_busy, tbl[i].e_err, 1'b0, 5'b0});
            @(negedge clk);
            abort = 1'b0;
            #1;
            check($sformatf("tbl%0d_b", i), {cnt_en, busy, err, done, 5'b0}, 9'b0);
        end

        // Counter starting above lo seeks downward
        @(negedge clk); ld = 1'b1; ld_val = 4'd12;
        @(negedge clk); ld = 1'b0;
        kick(4, 9, 0, 1);
        build(cnt, 4, 9, 0, 1, 0);
        run_q("seekdn", 0, 0, -1);

        // Continuous sweeps (sweep_cnt wraps), then abort during DOWN
        kick(0, 3, 0, 0);
        build(cnt, 0, 3, 0, 0, 18);
        run_q("cont", 0, 1, -1);

        // Frozen counter
        @(negedge clk); ld = 1'b1; ld_val = 4'd0;
        @(negedge clk); ld = 1'b0; freeze = 1'b1;
        kick(3, 8, 0, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); start = 1'b0; #1;
            check($sformatf("stall%0d", i), outs(), 9'b1_1_1_0_0_0000);
        end
        @(negedge clk); #1;
        check("stall_err", outs(), 9'b0_1_0_0_1_0000);
        @(negedge clk); #1;
        check("stall_err_end", {cnt_en, busy, err, 6'b0}, 9'b0);
        freeze = 1'b0;

        // Reset while holding at hi, then a normal run
        kick(2, 5, 7, 1);
        build(cnt, 2, 5, 7, 1, 0);
        run_q("prerst", 0, 0, 10);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); #1;
        check("midrst", outs(), 9'b0_1_0_0_0_0000);
        @(negedge clk); #1;
        check("midrst_hold", outs(), 9'b0_1_0_0_0_0000);
        rst_n = 1'b1;
        kick(2, 5, 1, 2);
        build(cnt, 2, 5, 1, 2, 0);
        run_q("postrst", 0, 0, -1);

        // Randomized runs with ignored start/config noise while busy
        for (int r = 0; r < 25; r++) begin
            l = $urandom_range(0, 14);
            h = $urandom_range(15, l + 1);
            d = $urandom_range(0, 3);
            s = $urandom_range(1, 3);
            kick(l, h, d, s);
            build(cnt, l, h, d, s, 0);
            run_q($sformatf("rand%0d", r), 1, 0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
